// File: rtl/regfile_seq.sv
// Access sequencer for the register-cell array: reads two operands, hands them
// to the ALU, waits for the result and optionally writes it back to rd.
module regfile_seq #(
  parameter int NREG = 16,
  parameter int AW   = 4,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_rn,
  input  logic [AW-1:0]   req_rm,
  input  logic [AW-1:0]   req_rd,
  input  logic            req_wb,
  output logic [NREG-1:0] ce_a,
  output logic [NREG-1:0] ce_b,
  output logic [NREG-1:0] ce_w,
  output logic            we,
  input  logic [DW-1:0]   bus_a,
  input  logic [DW-1:0]   bus_b,
  output logic [DW-1:0]   wr_data,
  output logic [DW-1:0]   op_a,
  output logic [DW-1:0]   op_b,
  output logic            op_valid,
  input  logic            res_valid,
  input  logic [DW-1:0]   res_data,
  output logic            done,
  output logic [2:0]      dbg_state
);

  // Handshake: a request transfers on a posedge where req_valid && req_ready;
  // req_ready is high only in IDLE, so the requester holds req_valid until then.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_rn;
  logic [AW-1:0]   r_rm;
  logic [AW-1:0]   r_rd;
  logic            r_wb;
  logic [DW-1:0]   r_op_a;
  logic [DW-1:0]   r_op_b;
  logic [DW-1:0]   r_wr_data;
  logic [NREG-1:0] w_sel_a;
  logic [NREG-1:0] w_sel_b;
  logic [NREG-1:0] w_sel_w;
  logic            w_accept;

  // Shifting past the top bit yields zero, so out-of-range addresses select nothing.
  assign w_sel_a  = ONE << r_rn;
  assign w_sel_b  = ONE << r_rm;
  assign w_sel_w  = ONE << r_rd;
  assign w_accept = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rn      <= '0;
      r_rm      <= '0;
      r_rd      <= '0;
      r_wb      <= 1'b0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rn <= req_rn;
        r_rm <= req_rm;
        r_rd <= req_rd;
        r_wb <= req_wb;
      end
      // A port with no cell selected sees a floating bus; force its operand to 0.
      if (r_state == S_READ) begin
        r_op_a <= (|w_sel_a) ? bus_a : '0;
        r_op_b <= (|w_sel_b) ? bus_b : '0;
      end
      if (r_state == S_EXEC && res_valid && r_wb) begin
        r_wr_data <= res_data;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    ce_a      = '0;
    ce_b      = '0;
    ce_w      = '0;
    we        = 1'b0;
    op_valid  = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_READ;
      end
      S_READ: begin
        ce_a   = w_sel_a;
        ce_b   = w_sel_b;
        w_next = S_EXEC;
      end
      S_EXEC: begin
        op_valid = 1'b1;
        if (res_valid) w_next = r_wb ? S_WRITE : S_DONE;
      end
      S_WRITE: begin
        ce_w   = w_sel_w;
        we     = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign wr_data   = r_wr_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a negedge-capturing register-cell model
// and an operand scoreboard.
module tb_regfile_seq;
  localparam int NREG = 13;
  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam logic [DW-1:0] FLOAT = 32'hBAD0_BAD0;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_valid, req_ready, req_wb;
  logic [AW-1:0]   req_rn, req_rm, req_rd;
  logic [NREG-1:0] ce_a, ce_b, ce_w;
  logic            we, op_valid, res_valid, done;
  logic [DW-1:0]   bus_a, bus_b, wr_data, op_a, op_b, res_data;
  logic [2:0]      dbg_state;

  regfile_seq #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rn(req_rn), .req_rm(req_rm), .req_rd(req_rd), .req_wb(req_wb),
    .ce_a(ce_a), .ce_b(ce_b), .ce_w(ce_w), .we(we),
    .bus_a(bus_a), .bus_b(bus_b), .wr_data(wr_data),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .res_valid(res_valid), .res_data(res_data), .done(done),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // register cells: capture on negedge, drive shared buses when selected
  logic [DW-1:0] cells [NREG];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(negedge clk) begin
    if (pre_en) cells[pre_addr] <= pre_data;
    else if (we) begin
      for (int i = 0; i < NREG; i++) if (ce_w[i]) cells[i] <= wr_data;
    end
  end

  always_comb begin
    bus_a = '0;
    bus_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (ce_a[i]) bus_a = bus_a | cells[i];
      if (ce_b[i]) bus_b = bus_b | cells[i];
    end
    if (ce_a == '0) bus_a = FLOAT;
    if (ce_b == '0) bus_b = FLOAT;
  end

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdl [NREG];
  logic [DW-1:0] exp_wd;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("miscompare at %s", tag);
    end
  endtask

  function automatic logic [NREG-1:0] oh(input logic [AW-1:0] a);
    oh = '0;
    if (int'(a) < NREG) oh[a] = 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(negedge clk);
    #1;
    pre_en = 1'b0;
    mdl[a] = d;
  endtask

  task automatic do_op(input logic [AW-1:0] rn, input logic [AW-1:0] rm,
                       input logic [AW-1:0] rd, input logic wb,
                       input logic [DW-1:0] res, input int dly, input bit stray);
    logic [DW-1:0] ea, eb;
    ea = (int'(rn) < NREG) ? mdl[rn] : '0;
    eb = (int'(rm) < NREG) ? mdl[rm] : '0;
    exp_q.push_back(ea);
    exp_q.push_back(eb);
    req_rn = rn; req_rm = rm; req_rd = rd; req_wb = wb; req_valid = 1'b1;
    chk("idle_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    req_rn = AW'($urandom); req_rm = AW'($urandom); req_rd = AW'($urandom); req_wb = ~wb;
    chk("read_ce_a", 32'(ce_a), 32'(oh(rn)));
    chk("read_ce_b", 32'(ce_b), 32'(oh(rm)));
    chk("read_ce_w", 32'(ce_w), 32'd0);
    chk("read_ready", 32'(req_ready), 32'd0);
    chk("read_opv", 32'(op_valid), 32'd0);
    res_valid = stray;
    res_data  = $urandom;
    tick();
    res_valid = 1'b0;
    chk("exec_opv", 32'(op_valid), 32'd1);
    chk("exec_op_a", op_a, exp_q.pop_front());
    chk("exec_op_b", op_b, exp_q.pop_front());
    chk("exec_ce_a", 32'(ce_a), 32'd0);
    repeat (dly) begin
      tick();
      chk("exec_hold_opv", 32'(op_valid), 32'd1);
      chk("exec_hold_op_a", op_a, ea);
      chk("exec_we", 32'(we), 32'd0);
    end
    res_valid = 1'b1;
    res_data  = res;
    tick();
    res_valid = 1'b0;
    res_data  = $urandom;
    chk("exit_opv", 32'(op_valid), 32'd0);
    if (wb) begin
      chk("write_we", 32'(we), 32'd1);
      chk("write_ce_w", 32'(ce_w), 32'(oh(rd)));
      chk("write_data", wr_data, res);
      exp_wd = res;
      if (int'(rd) < NREG) mdl[rd] = res;
      tick();
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_we", 32'(we), 32'd0);
    chk("done_ce_w", 32'(ce_w), 32'd0);
    chk("done_ready", 32'(req_ready), 32'd0);
    chk("done_wr_data", wr_data, exp_wd);
    tick();
    chk("after_done", 32'(done), 32'd0);
    chk("after_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < NREG; i++) chk($sformatf("cell%0d", i), cells[i], mdl[i]);
  endtask

  task automatic rst_mid(input bit in_write);
    req_rn = 4'd1; req_rm = 4'd2; req_rd = 4'd5; req_wb = 1'b1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rst_pre_opv", 32'(op_valid), 32'd1);
    if (in_write) begin
      res_valid = 1'b1;
      res_data  = 32'h0BAD_F00D;
      tick();
      res_valid = 1'b0;
      chk("rst_pre_we", 32'(we), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("rst_async_we", 32'(we), 32'd0);
    chk("rst_async_ce_w", 32'(ce_w), 32'd0);
    chk("rst_async_opv", 32'(op_valid), 32'd0);
    chk("rst_async_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    #1;
    exp_wd = '0;
    chk("rst_cell5", cells[5], mdl[5]);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 1'b0; req_rn = '0; req_rm = '0; req_rd = '0; req_wb = 1'b0;
    res_valid = 1'b0; res_data = '0; exp_wd = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ce_a", 32'(ce_a), 32'd0);
    chk("reset_we", 32'(we), 32'd0);
    chk("reset_opv", 32'(op_valid), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    chk("reset_op_a", op_a, 32'd0);
    chk("reset_wr_data", wr_data, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("reset_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < NREG; i++) preload(AW'(i), $urandom);
    preload(4'd3, 32'h0000_0005);
    preload(4'd7, 32'h0000_000A);
    preload(4'd4, 32'h1234_5678);
    tick();

    do_op(4'd3, 4'd7, 4'd9, 1'b1, 32'h0000_000F, 0, 1'b0);
    do_op(4'd4, 4'd4, 4'd4, 1'b1, 32'hFFFF_FFFF, 2, 1'b0);
    do_op(4'd1, 4'd5, 4'd6, 1'b0, 32'hDEAD_BEEF, 1, 1'b0);

    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("stray_idle_state", 32'(dbg_state), 32'd0);
    chk("stray_idle_opv", 32'(op_valid), 32'd0);

    do_op(4'd14, 4'd2, 4'd15, 1'b1, 32'h1357_9BDF, 0, 1'b1);

    rst_mid(1'b0);
    rst_mid(1'b1);

    for (int k = 0; k < 8; k++)
      do_op(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
            AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            $urandom, $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_seq.md
Name: regfile_seq

Overview:
- Access sequencer that sits directly upstream of the 32-bit register cells in the calculator's register file.
- Takes one operation request (rn, rm, rd, write-back flag) per handshake and drives the one-hot CE1/CE2/CE3 selects and WE of the register array.
- Captures the two tristate read buses into operand registers and hands them to the ALU.
- Waits for the ALU result, then writes it back to rd.

Parameters:
NREG, 16, number of register cells (one select bit each)
AW, 4, register address width
DW, 32, data width

Ports:
clk  in  1  system clock; sequencer acts on posedge, register cells capture on negedge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer idle, request accepted when req_valid&req_ready at posedge
req_rn  in  AW  operand A register address
req_rm  in  AW  operand B register address
req_rd  in  AW  destination register address
req_wb  in  1  1 = write result to rd, 0 = discard result
ce_a  out  NREG  one-hot read select, port A (CE1 of each cell)
ce_b  out  NREG  one-hot read select, port B (CE2 of each cell)
ce_w  out  NREG  one-hot write select (CE3 of each cell)
we  out  1  write enable to all cells
bus_a  in  DW  shared tristate read bus A (DA of all cells)
bus_b  in  DW  shared tristate read bus B (DB of all cells)
wr_data  out  DW  write data to all cells (Di)
op_a  out  DW  latched operand A to ALU
op_b  out  DW  latched operand B to ALU
op_valid  out  1  operands valid, ALU may compute
res_valid  in  1  ALU result valid
res_data  in  DW  ALU result
done  out  1  one-cycle pulse, operation retired

Behaviour:
- Reset (async, immediate): state=IDLE; ce_a=ce_b=ce_w=0, we=0, op_valid=0, done=0; op_a=op_b=wr_data=0; req_ready=1 after deassert. Reset mid-operation abandons the op with no write. Request fields are latched into rn_q/rm_q/rd_q/wb_q at acceptance.
- FSM states: IDLE, READ, EXEC, WRITE, DONE.
- IDLE:
  - req_ready=1; all selects 0, so buses float and are never sampled.
  - On accept → READ.
- READ (exactly 1 cycle):
  - ce_a=onehot(rn_q), ce_b=onehot(rm_q).
  - At the closing posedge, op_a<=bus_a and op_b<=bus_b; selects drop to 0 → EXEC.
  - rn_q==rm_q is legal: both ports select the same cell.
  - Address ≥ NREG: that port's select is all-zero and the operand is forced to 0, never sampled from the floating bus.
- EXEC:
  - op_valid=1; op_a/op_b held stable.
  - Wait indefinitely for res_valid.
  - On res_valid with wb_q=1: wr_data<=res_data → WRITE.
  - On res_valid with wb_q=0: → DONE, wr_data unchanged.
  - op_valid falls on the exit edge.
- WRITE (exactly 1 cycle):
  - ce_w=onehot(rd_q), we=1, wr_data stable for the full cycle, so the cell captures at the mid-cycle negedge.
  - rd_q ≥ NREG: ce_w=0, no cell written, done still pulses.
  - → DONE.
- DONE (1 cycle): done=1, req_ready=0 → IDLE.
- Latency: accept edge E0; READ in cycle 1; op_valid from cycle 2. Earliest result at cycle 2 gives WRITE in cycle 3, DONE in cycle 4, next accept at E5. Throughput is one op per ≥5 cycles.
- res_valid outside EXEC is ignored. req_valid outside IDLE is not accepted; the requester must hold it.
- Invariants:
  - at most one bit set in each of ce_a/ce_b/ce_w;
  - we=1 only in WRITE and only with ce_w≠0, or in WRITE with an out-of-range rd;
  - ce_w never overlaps READ;
  - rd==rn is safe because the read completes before the write.
- wr_data and op_a/op_b hold their last values between operations.

Test Plan:
- Preload r3=0x0000_0005 and r7=0x0000_000A. Request rn=3, rm=7, rd=9, wb=1; ALU returns 0x0F at the first op_valid cycle. Required: op_a=5, op_b=0xA; ce_w=0x0200 and we=1 for exactly one cycle; r9=0x0F; done at cycle 4; req_ready returns at cycle 5.
- rn=rm=4 with r4=0x1234_5678 → ce_a=ce_b=0x0010, op_a=op_b=0x1234_5678. Also rd=rn=4, result 0xFFFF_FFFF, 3-cycle ALU delay → op_valid held 3 cycles, r4=0xFFFF_FFFF afterwards.
- wb=0, res_data=0xDEAD_BEEF → we stays 0 throughout, no cell changes, wr_data keeps its prior value, done pulses once.
- Assert rst in EXEC and separately in WRITE → all selects/we/op_valid drop asynchronously, state IDLE; the target register keeps its old value when rst rises before the negedge; req_ready=1 after release.
- NREG=13: rn=14, rm=2, rd=15 → ce_a=0, op_a=0, op_b=r2; ce_w=0 in WRITE, no cell written, done pulses. Also a stray res_valid pulse in IDLE and READ → ignored.
